bp_me_wb_client_bridge: RTL and testbench



---
 rtl/bp_me_wb_client_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_bp_me_wb_client_bridge.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bp_me_wb_client_bridge.sv
// Wishbone classic (non-pipelined) slave to BedRock uncached memory command
// bridge. Each Wishbone cycle becomes one BedRock uc_rd/uc_wr command; the
// BedRock response is returned as a single-cycle Wishbone acknowledge.
//
// Header layout, MSB first:
//   payload {lce_id, did, way_id, state}, size, addr, subop, msg_type
//
// Handshake semantics on the BedRock side: a beat transfers on a rising clock
// edge where valid and ready are both high. The valid signal never depends on
// ready. Ready may depend on valid. Valid stays asserted and the header and
// data stay stable until the transfer happens.
module bp_me_wb_client_bridge #(
    parameter int paddr_width_p  = 40,
    parameter int did_width_p    = 3,
    parameter int lce_id_width_p = 4,
    parameter int lce_assoc_p    = 8,
    parameter int data_width_p   = 64,
    localparam int way_id_width_lp    = $clog2(lce_assoc_p),
    localparam int mem_header_width_lp = lce_id_width_p + did_width_p + way_id_width_lp
                                         + 3 + 3 + paddr_width_p + 4 + 3,
    localparam int wbone_addr_width_lp = paddr_width_p - 3
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [lce_id_width_p-1:0]      lce_id_i,
    input  logic [did_width_p-1:0]         did_i,
    output logic [mem_header_width_lp-1:0] mem_cmd_header_o,
    output logic [data_width_p-1:0]        mem_cmd_data_o,
    output logic                           mem_cmd_v_o,
    input  logic                           mem_cmd_ready_i,
    input  logic [mem_header_width_lp-1:0] mem_resp_header_i,
    input  logic [data_width_p-1:0]        mem_resp_data_i,
    input  logic                           mem_resp_v_i,
    output logic                           mem_resp_ready_o,
    input  logic [wbone_addr_width_lp-1:0] adr_i,
    input  logic [data_width_p-1:0]        dat_i,
    input  logic                           cyc_i,
    input  logic                           stb_i,
    input  logic [data_width_p/8-1:0]      sel_i,
    input  logic                           we_i,
    output logic [data_width_p-1:0]        dat_o,
    output logic                           ack_o
);

    if (data_width_p != 64) begin : g_bad_width
        $error("bp_me_wb_client_bridge supports only data_width_p == 64");
    end

    localparam logic [2:0] msg_uc_rd_lp = 3'd2;
    localparam logic [2:0] msg_uc_wr_lp = 3'd3;
    localparam logic [3:0] subop_store_lp = 4'd0;
    localparam logic [2:0] size_1_lp = 3'd0;
    localparam logic [2:0] size_2_lp = 3'd1;
    localparam logic [2:0] size_4_lp = 3'd2;
    localparam logic [2:0] size_8_lp = 3'd3;

    typedef struct packed {
        logic [lce_id_width_p-1:0]   lce_id;
        logic [did_width_p-1:0]      did;
        logic [way_id_width_lp-1:0]  way_id;
        logic [2:0]                  state;
    } payload_s;

    typedef struct packed {
        payload_s                    payload;
        logic [2:0]                  size;
        logic [paddr_width_p-1:0]    addr;
        logic [3:0]                  subop;
        logic [2:0]                  msg_type;
    } mem_header_s;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } state_e;

    state_e      state_r, state_n;
    mem_header_s hdr_r, hdr_n;
    logic [63:0] data_r, wdata_n, shifted;
    logic [63:0] dat_r;
    logic [2:0]  size_n, offset_n;
    logic        capture, resp_fire;

    // Response header carries nothing the Wishbone side needs.
    logic unused_resp_header;
    assign unused_resp_header = ^mem_resp_header_i;

    // Decode byte selects into a naturally aligned size/offset and build the
    // replicated write data and the command header.
    always_comb begin
        size_n   = size_8_lp;
        offset_n = 3'd0;
        case (sel_i)
            8'h01: begin size_n = size_1_lp; offset_n = 3'd0; end
            8'h02: begin size_n = size_1_lp; offset_n = 3'd1; end
            8'h04: begin size_n = size_1_lp; offset_n = 3'd2; end
            8'h08: begin size_n = size_1_lp; offset_n = 3'd3; end
            8'h10: begin size_n = size_1_lp; offset_n = 3'd4; end
            8'h20: begin size_n = size_1_lp; offset_n = 3'd5; end
            8'h40: begin size_n = size_1_lp; offset_n = 3'd6; end
            8'h80: begin size_n = size_1_lp; offset_n = 3'd7; end
            8'h03: begin size_n = size_2_lp; offset_n = 3'd0; end
            8'h0C: begin size_n = size_2_lp; offset_n = 3'd2; end
            8'h30: begin size_n = size_2_lp; offset_n = 3'd4; end
            8'hC0: begin size_n = size_2_lp; offset_n = 3'd6; end
            8'h0F: begin size_n = size_4_lp; offset_n = 3'd0; end
            8'hF0: begin size_n = size_4_lp; offset_n = 3'd4; end
            default: begin size_n = size_8_lp; offset_n = 3'd0; end
        endcase

        shifted = dat_i >> {offset_n, 3'b000};
        case (size_n)
            size_1_lp: wdata_n = {8{shifted[7:0]}};
            size_2_lp: wdata_n = {4{shifted[15:0]}};
            size_4_lp: wdata_n = {2{shifted[31:0]}};
            default:   wdata_n = shifted;
        endcase
        if (!we_i) begin
            wdata_n = '0;
        end

        hdr_n                = '0;
        hdr_n.msg_type       = we_i ? msg_uc_wr_lp : msg_uc_rd_lp;
        hdr_n.subop          = subop_store_lp;
        hdr_n.addr           = {adr_i, offset_n};
        hdr_n.size           = size_n;
        hdr_n.payload.lce_id = lce_id_i;
        hdr_n.payload.did    = did_i;
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and handshake outputs; one transaction outstanding at a time.
    always_comb begin
        state_n          = state_r;
        mem_cmd_v_o      = 1'b0;
        mem_resp_ready_o = 1'b0;
        ack_o            = 1'b0;
        capture          = 1'b0;
        resp_fire        = 1'b0;
        case (state_r)
            IDLE: begin
                if (cyc_i && stb_i) begin
                    capture = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                mem_cmd_v_o = 1'b1;
                if (mem_cmd_ready_i) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                mem_resp_ready_o = 1'b1;
                if (mem_resp_v_i) begin
                    resp_fire = 1'b1;
                    state_n   = ACK;
                end
            end
            ACK: begin
                // A master that dropped cyc has abandoned the cycle: no ack.
                ack_o   = cyc_i;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Command capture and response data registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hdr_r  <= '0;
            data_r <= '0;
            dat_r  <= '0;
        end else begin
            if (capture) begin
                hdr_r  <= hdr_n;
                data_r <= wdata_n;
            end
            if (resp_fire) begin
                dat_r <= mem_resp_data_i;
            end
        end
    end

    assign mem_cmd_header_o = hdr_r;
    assign mem_cmd_data_o   = data_r;
    assign dat_o            = dat_r;

endmodule

// File: tb/tb_bp_me_wb_client_bridge.sv
// Directed bench for bp_me_wb_client_bridge: Wishbone transactions with
// hand-computed BedRock command headers, data and acknowledge timing.
module tb_bp_me_wb_client_bridge;

    localparam int hw = 63;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [3:0]    lce_id_i;
    logic [2:0]    did_i;
    logic [hw-1:0] mem_cmd_header_o;
    logic [63:0]   mem_cmd_data_o;
    logic          mem_cmd_v_o;
    logic          mem_cmd_ready_i;
    logic [hw-1:0] mem_resp_header_i;
    logic [63:0]   mem_resp_data_i;
    logic          mem_resp_v_i;
    logic          mem_resp_ready_o;
    logic [36:0]   adr_i;
    logic [63:0]   dat_i;
    logic          cyc_i;
    logic          stb_i;
    logic [7:0]    sel_i;
    logic          we_i;
    logic [63:0]   dat_o;
    logic          ack_o;

    int n_checks = 0;
    int n_fail   = 0;

    bp_me_wb_client_bridge dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .lce_id_i          (lce_id_i),
        .did_i             (did_i),
        .mem_cmd_header_o  (mem_cmd_header_o),
        .mem_cmd_data_o    (mem_cmd_data_o),
        .mem_cmd_v_o       (mem_cmd_v_o),
        .mem_cmd_ready_i   (mem_cmd_ready_i),
        .mem_resp_header_i (mem_resp_header_i),
        .mem_resp_data_i   (mem_resp_data_i),
        .mem_resp_v_i      (mem_resp_v_i),
        .mem_resp_ready_o  (mem_resp_ready_o),
        .adr_i             (adr_i),
        .dat_i             (dat_i),
        .cyc_i             (cyc_i),
        .stb_i             (stb_i),
        .sel_i             (sel_i),
        .we_i              (we_i),
        .dat_o             (dat_o),
        .ack_o             (ack_o)
    );

    // Clock generation.
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Expected header: {lce_id=5, did=3, way=0, state=0, size, addr, subop=store, msg}.
    function automatic logic [hw-1:0] mk_hdr(input logic [2:0] msg, input logic [39:0] addr,
                                            input logic [2:0] size);
        return {4'h5, 3'h3, 3'b000, 3'b000, size, addr, 4'h0, msg};
    endfunction

    // Drives one Wishbone cycle and checks the command, the backpressure
    // behaviour and the acknowledge timing along the way.
    task automatic run_txn(input string tag, input logic [36:0] adr, input logic [7:0] sel,
                           input logic we, input logic [63:0] dat,
                           input logic [39:0] exp_addr, input logic [2:0] exp_size,
                           input logic [63:0] exp_data, input logic [63:0] resp_data,
                           input int cmd_wait, input int resp_wait, input bit abort);
        logic [hw-1:0] eh;
        eh = mk_hdr(we ? 3'd3 : 3'd2, exp_addr, exp_size);
        adr_i = adr; sel_i = sel; we_i = we; dat_i = dat;
        cyc_i = 1'b1; stb_i = 1'b1; mem_cmd_ready_i = 1'b0;
        #1;
        check({tag, "_capture_v"}, {63'b0, mem_cmd_v_o}, 64'd0);
        tick();
        for (int i = 0; i < cmd_wait; i++) begin
            check({tag, "_bp_v"}, {63'b0, mem_cmd_v_o}, 64'd1);
            check({tag, "_bp_hdr"}, {1'b0, mem_cmd_header_o}, {1'b0, eh});
            tick();
        end
        check({tag, "_v"}, {63'b0, mem_cmd_v_o}, 64'd1);
        check({tag, "_hdr"}, {1'b0, mem_cmd_header_o}, {1'b0, eh});
        check({tag, "_data"}, mem_cmd_data_o, exp_data);
        mem_cmd_ready_i = 1'b1;
        tick();
        mem_cmd_ready_i = 1'b0;
        check({tag, "_wait_v"}, {63'b0, mem_cmd_v_o}, 64'd0);
        check({tag, "_wait_rdy"}, {63'b0, mem_resp_ready_o}, 64'd1);
        for (int i = 0; i < resp_wait; i++) begin
            check({tag, "_dly_ack"}, {63'b0, ack_o}, 64'd0);
            check({tag, "_dly_v"}, {63'b0, mem_cmd_v_o}, 64'd0);
            tick();
        end
        mem_resp_v_i = 1'b1; mem_resp_data_i = resp_data;
        tick();
        mem_resp_v_i = 1'b0; mem_resp_data_i = 64'h5555_5555_5555_5555;
        if (abort) begin
            cyc_i = 1'b0; stb_i = 1'b0;
            #1;
            check({tag, "_abort_ack"}, {63'b0, ack_o}, 64'd0);
        end else begin
            check({tag, "_ack"}, {63'b0, ack_o}, 64'd1);
        end
        check({tag, "_dat_o"}, dat_o, resp_data);
        tick();
        cyc_i = 1'b0; stb_i = 1'b0;
        check({tag, "_ack_drop"}, {63'b0, ack_o}, 64'd0);
        check({tag, "_idle_v"}, {63'b0, mem_cmd_v_o}, 64'd0);
        tick();
        check({tag, "_no_dup"}, {63'b0, mem_cmd_v_o}, 64'd0);
        check({tag, "_no_ack2"}, {63'b0, ack_o}, 64'd0);
    endtask

    // Stimulus, reset checks, directed transactions and the final report.
    initial begin
        reset_i = 1'b1; lce_id_i = 4'h5; did_i = 3'h3;
        mem_cmd_ready_i = 1'b0; mem_resp_header_i = '0; mem_resp_data_i = '0;
        mem_resp_v_i = 1'b0; adr_i = '0; dat_i = '0; cyc_i = 1'b0; stb_i = 1'b0;
        sel_i = '0; we_i = 1'b0;
        tick();
        reset_i = 1'b0;
        check("rst_cmd_v", {63'b0, mem_cmd_v_o}, 64'd0);
        check("rst_resp_rdy", {63'b0, mem_resp_ready_o}, 64'd0);
        check("rst_ack", {63'b0, ack_o}, 64'd0);
        check("rst_dat_o", dat_o, 64'd0);

        run_txn("wr64", 37'h10, 8'hFF, 1'b1, 64'h0123_4567_89AB_CDEF,
                40'h80, 3'd3, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_1111, 0, 0, 1'b0);
        run_txn("wr8", 37'h2, 8'h20, 1'b1, 64'h0000_AB00_0000_0000,
                40'h15, 3'd0, 64'hABAB_ABAB_ABAB_ABAB, 64'h0, 0, 0, 1'b0);
        run_txn("rd32", 37'h4, 8'hF0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
                40'h24, 3'd2, 64'h0, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 1'b0);
        run_txn("bp_wr16", 37'h7, 8'h0C, 1'b1, 64'h0000_0000_BEEF_0000,
                40'h3A, 3'd1, 64'hBEEF_BEEF_BEEF_BEEF, 64'h0000_0000_0000_0077, 5, 7, 1'b0);
        run_txn("wr16_hi", 37'h1, 8'hC0, 1'b1, 64'h5A5A_0000_0000_0000,
                40'h0E, 3'd1, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0000_0000_0000_0088, 0, 2, 1'b0);
        run_txn("rd_badsel", 37'h1, 8'h05, 1'b0, 64'h1234,
                40'h08, 3'd3, 64'h0, 64'hCAFE_F00D_0000_0001, 1, 0, 1'b0);
        run_txn("wr_sel0", 37'h3, 8'h00, 1'b1, 64'hFEDC_BA98_7654_3210,
                40'h18, 3'd3, 64'hFEDC_BA98_7654_3210, 64'h0000_0000_0000_0099, 0, 0, 1'b0);
        run_txn("abort", 37'h6, 8'h01, 1'b0, 64'h0,
                40'h30, 3'd0, 64'h0, 64'h0000_0000_0000_00AA, 0, 1, 1'b1);

        // Reset while waiting for a response: silent abort, no ack.
        adr_i = 37'h9; sel_i = 8'hFF; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
        tick();
        mem_cmd_ready_i = 1'b1;
        tick();
        mem_cmd_ready_i = 1'b0;
        check("rstw_in_wait", {63'b0, mem_resp_ready_o}, 64'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
        check("rstw_resp_rdy", {63'b0, mem_resp_ready_o}, 64'd0);
        check("rstw_cmd_v", {63'b0, mem_cmd_v_o}, 64'd0);
        check("rstw_ack", {63'b0, ack_o}, 64'd0);
        check("rstw_dat_o", dat_o, 64'd0);
        mem_resp_v_i = 1'b1; mem_resp_data_i = 64'h1111_2222_3333_4444;
        tick();
        mem_resp_v_i = 1'b0;
        check("rstw_late_ack", {63'b0, ack_o}, 64'd0);
        check("rstw_late_dat", dat_o, 64'd0);
        tick();
        check("rstw_late_ack2", {63'b0, ack_o}, 64'd0);

        run_txn("post_rst", 37'h20, 8'h0F, 1'b1, 64'h0000_0000_1357_9BDF,
                40'h100, 3'd2, 64'h1357_9BDF_1357_9BDF, 64'h0000_0000_0000_00BB, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
